// File: rtl/axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_pkg
// Shared types and constants for the memory-stage AXI load/store engine:
//   - state_e       : control FSM states
//   - SIZE_*        : access size encodings on the request interface
//   - BURST_INCR    : AXI burst type driven on every request
//   - RESP_OKAY     : AXI OKAY response code
//   - lane_mask()   : 4-bit byte-enable pattern for an access size
//   - is_misaligned(): alignment / reserved-size check for a request
// -----------------------------------------------------------------------------
package axi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Byte enables for an access of the given size, before lane shifting.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001;
      SIZE_HALF: m = 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // Reserved size is folded into the misaligned error path.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between a 32-bit request and a wide AXI
// data bus.
// Ports:
//   off_i      : byte offset of the access within the bus word
//   size_i     : access size (SIZE_BYTE/HALF/WORD)
//   sign_ext_i : loads only, 1 = sign-extend, 0 = zero-extend
//   wdata_in_i : right-aligned store data
//   rdata_i    : full-width read beat
//   wdata_o    : store data shifted onto its byte lanes, other bits 0
//   wstrb_o    : byte strobes matching wdata_o
//   load_o     : extracted and extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import axi_mem_pkg::*;
#(
  parameter int BUS_W = 512,
  parameter int OFF_W = $clog2(BUS_W / 8)
) (
  input  logic [OFF_W-1:0]   off_i,
  input  logic [1:0]         size_i,
  input  logic               sign_ext_i,
  input  logic [31:0]        wdata_in_i,
  input  logic [BUS_W-1:0]   rdata_i,
  output logic [BUS_W-1:0]   wdata_o,
  output logic [BUS_W/8-1:0] wstrb_o,
  output logic [31:0]        load_o
);

  localparam int STRB_W = BUS_W / 8;

  logic [OFF_W+2:0] shamt_s;
  logic [31:0]      data_mask_s;
  logic [31:0]      lane_s;

  // Write-data / strobe placement and read-lane extraction.
  always_comb begin
    shamt_s = {off_i, 3'b000};

    case (size_i)
      SIZE_BYTE: data_mask_s = 32'h0000_00FF;
      SIZE_HALF: data_mask_s = 32'h0000_FFFF;
      default:   data_mask_s = 32'hFFFF_FFFF;
    endcase

    wdata_o = {{(BUS_W-32){1'b0}}, (wdata_in_i & data_mask_s)} << shamt_s;
    wstrb_o = {{(STRB_W-4){1'b0}}, lane_mask(size_i)} << off_i;

    // Truncating cast keeps only the addressed lane after the right shift.
    lane_s = 32'(rdata_i >> shamt_s);

    case (size_i)
      SIZE_BYTE: load_o = {{24{sign_ext_i & lane_s[7]}}, lane_s[7:0]};
      SIZE_HALF: load_o = {{16{sign_ext_i & lane_s[15]}}, lane_s[15:0]};
      default:   load_o = lane_s;
    endcase
  end

endmodule

// File: rtl/axi_mem_unit.sv
// -----------------------------------------------------------------------------
// axi_mem_unit
// Memory-stage load/store engine: converts one 8/16/32-bit request into a
// single-beat AXI4 read or write on a BUS_W-wide data bus and returns a
// one-cycle done pulse with result and error.
// Ports:
//   clk, rstn                      : clock, synchronous active-low reset
//   enable, is_store, size,
//   sign_ext, addr, wdata_in       : request (sampled only when idle)
//   done, err, rdata_out, busy     : completion / status
//   ar*, r*                        : AXI read address / data channels
//   aw*, w*, b*                    : AXI write address / data / response
// All handshake and data outputs are registered; burst attributes are
// constant single-beat INCR at full bus width.
// -----------------------------------------------------------------------------
module axi_mem_unit
  import axi_mem_pkg::*;
#(
  parameter int         ADDR_W = 29,
  parameter int         BUS_W  = 512,
  parameter logic [3:0] ID     = 4'd0
) (
  input  logic               clk,
  input  logic               rstn,
  // request
  input  logic               enable,
  input  logic               is_store,
  input  logic [1:0]         size,
  input  logic               sign_ext,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata_in,
  // completion
  output logic               done,
  output logic               err,
  output logic [31:0]        rdata_out,
  output logic               busy,
  // AXI read address
  output logic [ADDR_W-1:0]  araddr,
  output logic               arvalid,
  input  logic               arready,
  output logic [3:0]         arid,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  // AXI read data
  input  logic [BUS_W-1:0]   rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  input  logic               rlast,
  output logic               rready,
  // AXI write address
  output logic [ADDR_W-1:0]  awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [3:0]         awid,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  // AXI write data
  output logic [BUS_W-1:0]   wdata,
  output logic [BUS_W/8-1:0] wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  // AXI write response
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  localparam int         STRB_W = BUS_W / 8;
  localparam int         OFF_W  = $clog2(STRB_W);
  localparam logic [2:0] AXSIZE = 3'(OFF_W);

  state_e              state_q, state_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                wlast_q, wlast_d;
  logic                bready_q, bready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [31:0]         rdata_out_q, rdata_out_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [BUS_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          size_q, size_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                sign_q, sign_d;

  logic [ADDR_W-1:0]   bus_addr_s;
  logic                idle_s;
  logic [OFF_W-1:0]    algn_off_s;
  logic [1:0]          algn_size_s;
  logic [BUS_W-1:0]    algn_wdata_s;
  logic [STRB_W-1:0]   algn_wstrb_s;
  logic [31:0]         algn_load_s;
  logic                unused_s;

  // Single-beat transfers: rlast carries no information here.
  assign unused_s = rlast;

  assign bus_addr_s = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign idle_s     = (state_q == ST_IDLE);

  // The write path is evaluated from the live request at accept time so the
  // shifted data can be registered together with awvalid/wvalid; the read
  // path uses the latched request while the data beat arrives.
  assign algn_off_s  = idle_s ? addr[OFF_W-1:0] : off_q;
  assign algn_size_s = idle_s ? size : size_q;

  mem_lane_align #(
    .BUS_W (BUS_W),
    .OFF_W (OFF_W)
  ) u_align (
    .off_i      (algn_off_s),
    .size_i     (algn_size_s),
    .sign_ext_i (sign_q),
    .wdata_in_i (wdata_in),
    .rdata_i    (rdata),
    .wdata_o    (algn_wdata_s),
    .wstrb_o    (algn_wstrb_s),
    .load_o     (algn_load_s)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    done_d      = 1'b0;
    err_d       = err_q;
    busy_d      = busy_q;
    rdata_out_d = rdata_out_q;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    off_d       = off_q;
    sign_d      = sign_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          size_d = size;
          off_d  = addr[OFF_W-1:0];
          sign_d = sign_ext;
          if (is_misaligned(size, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (is_store) begin
            awaddr_d  = bus_addr_s;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
            wdata_d   = algn_wdata_s;
            wstrb_d   = algn_wstrb_s;
            state_d   = ST_WADDR;
          end else begin
            araddr_d  = bus_addr_s;
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else begin
          state_d = ST_RADDR;
        end
      end

      ST_RDATA: begin
        if (rvalid) begin
          rdata_out_d = algn_load_s;
          err_d       = (rresp != RESP_OKAY);
          rready_d    = 1'b0;
          state_d     = ST_FIN;
        end else begin
          state_d = ST_RDATA;
        end
      end

      ST_WADDR: begin
        // Address and data channels complete independently, in any order.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        wlast_d   = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end else begin
          state_d = ST_WADDR;
        end
      end

      ST_WRESP: begin
        if (bvalid) begin
          err_d    = (bresp != RESP_OKAY);
          bready_d = 1'b0;
          state_d  = ST_FIN;
        end else begin
          state_d = ST_WRESP;
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wlast_d   = 1'b0;
        bready_d  = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_out_q <= 32'd0;
      araddr_q    <= {ADDR_W{1'b0}};
      awaddr_q    <= {ADDR_W{1'b0}};
      wdata_q     <= {BUS_W{1'b0}};
      wstrb_q     <= {STRB_W{1'b0}};
      size_q      <= 2'b00;
      off_q       <= {OFF_W{1'b0}};
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rdata_out_q <= rdata_out_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sign_q      <= sign_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign rdata_out = rdata_out_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;

  assign arid    = ID;
  assign awid    = ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = AXSIZE;
  assign awsize  = AXSIZE;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;

endmodule

// File: tb/tb_axi_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_unit
// Directed bench for axi_mem_unit with a cycle-stepped AXI slave model that
// can delay awready. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_axi_mem_unit;

  localparam int ADDR_W = 29;
  localparam int BUS_W  = 512;
  localparam int STRB_W = BUS_W / 8;

  logic               clk;
  logic               rstn;
  logic               enable;
  logic               is_store;
  logic [1:0]         size;
  logic               sign_ext;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        wdata_in;
  logic               done;
  logic               err;
  logic [31:0]        rdata_out;
  logic               busy;
  logic [ADDR_W-1:0]  araddr;
  logic               arvalid;
  logic               arready;
  logic [3:0]         arid;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [BUS_W-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rlast;
  logic               rready;
  logic [ADDR_W-1:0]  awaddr;
  logic               awvalid;
  logic               awready;
  logic [3:0]         awid;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic [BUS_W-1:0]   wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  axi_mem_unit #(
    .ADDR_W (ADDR_W),
    .BUS_W  (BUS_W),
    .ID     (4'd0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .is_store  (is_store),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata_in  (wdata_in),
    .done      (done),
    .err       (err),
    .rdata_out (rdata_out),
    .busy      (busy),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rlast     (rlast),
    .rready    (rready),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by xfer
  int                r_lat, r_ar, r_aw, r_w, r_b, r_arv, r_awv, r_wv;
  logic              busy1, busy_done, wlast_seen;
  logic [ADDR_W-1:0] araddr_seen, awaddr_seen;
  logic [BUS_W-1:0]  wdata_seen;
  logic [STRB_W-1:0] wstrb_seen;
  logic [BUS_W-1:0]  bus;
  logic [BUS_W-1:0]  exp_wd;
  logic [STRB_W-1:0] exp_st;
  int                stray;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    enable = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata_in = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  // One request, driven from a negedge; the slave answers each cycle.
  task automatic xfer(input logic st, input logic [1:0] sz, input logic sx,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                      input int aw_dly, input logic [1:0] resp,
                      input logic [BUS_W-1:0] rbus, input logic poke);
    is_store = st; size = sz; sign_ext = sx; addr = a; wdata_in = wd;
    enable = 1'b1;
    r_lat = 0; r_ar = 0; r_aw = 0; r_w = 0; r_b = 0;
    r_arv = 0; r_awv = 0; r_wv = 0;
    busy1 = 1'b0; busy_done = 1'b1; wlast_seen = 1'b0;
    araddr_seen = '0; awaddr_seen = '0; wdata_seen = '0; wstrb_seen = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      enable = (poke && cyc == 2);
      if (cyc == 1) busy1 = busy;
      if (done) begin
        r_lat = cyc;
        busy_done = busy;
        break;
      end
      if (arvalid) r_arv++;
      if (awvalid) r_awv++;
      if (wvalid)  r_wv++;
      arready = arvalid;
      rvalid  = rready; rdata = rbus; rresp = resp; rlast = rready;
      awready = awvalid && (r_awv > aw_dly);
      wready  = 1'b1;
      bvalid  = bready; bresp = resp;
      if (arvalid && arready) begin r_ar++; araddr_seen = araddr; end
      if (awvalid && awready) begin r_aw++; awaddr_seen = awaddr; end
      if (wvalid && wready) begin
        r_w++; wdata_seen = wdata; wstrb_seen = wstrb; wlast_seen = wlast;
      end
      if (bvalid && bready) r_b++;
    end
    clear_inputs();
    check_eq("xfer_completes", 512'(r_lat != 0), 512'(1));
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);

    // reset state and constant attributes
    check_eq("rst_valids", 512'({arvalid, awvalid, wvalid, rready, bready, wlast}), 512'(0));
    check_eq("rst_status", 512'({done, err, busy}), 512'(0));
    check_eq("rst_rdata_out", 512'(rdata_out), 512'(0));
    check_eq("rst_wdata", 512'(wdata), 512'(0));
    check_eq("rst_wstrb", 512'(wstrb), 512'(0));
    check_eq("rst_addr", 512'({araddr, awaddr}), 512'(0));
    check_eq("const_len", 512'({arlen, awlen}), 512'(0));
    check_eq("const_burst", 512'({arburst, awburst}), 512'(4'b0101));
    check_eq("const_size", 512'({arsize, awsize}), 512'(6'o66));
    check_eq("const_id", 512'({arid, awid}), 512'(0));
    rstn = 1'b1;
    @(negedge clk);

    // load word 0x44, DEADBEEF at byte 4
    bus = 512'hDEADBEEF;
    bus = bus << 32;
    xfer(1'b0, 2'b10, 1'b0, 29'h44, 32'd0, 0, 2'b00, bus, 1'b0);
    check_eq("lw_latency", 512'(r_lat), 512'(4));
    check_eq("lw_araddr", 512'(araddr_seen), 512'(29'h40));
    check_eq("lw_rdata", 512'(rdata_out), 512'(32'hDEADBEEF));
    check_eq("lw_err", 512'(err), 512'(0));
    check_eq("lw_busy_accept", 512'(busy1), 512'(1));
    check_eq("lw_busy_done", 512'(busy_done), 512'(0));
    check_eq("lw_ar_hs", 512'(r_ar), 512'(1));

    // load byte 0x3F, byte 63 = 0x80, sign and zero extended
    bus = {8'h80, {63{8'h5A}}};
    xfer(1'b0, 2'b00, 1'b1, 29'h3F, 32'd0, 0, 2'b00, bus, 1'b0);
    check_eq("lb_sext", 512'(rdata_out), 512'(32'hFFFFFF80));
    xfer(1'b0, 2'b00, 1'b0, 29'h3F, 32'd0, 0, 2'b00, bus, 1'b0);
    check_eq("lb_zext", 512'(rdata_out), 512'(32'h00000080));

    // store half 0x1234 at 0x06, awready delayed 3 cycles
    xfer(1'b1, 2'b01, 1'b0, 29'h06, 32'hABCD1234, 3, 2'b00, '0, 1'b0);
    exp_wd = 512'h1234;
    exp_wd = exp_wd << 48;
    check_eq("sh_wdata", wdata_seen, exp_wd);
    check_eq("sh_wstrb", 512'(wstrb_seen), 512'(64'hC0));
    check_eq("sh_wlast", 512'(wlast_seen), 512'(1));
    check_eq("sh_wvalid_cycles", 512'(r_wv), 512'(1));
    check_eq("sh_awvalid_cycles", 512'(r_awv), 512'(4));
    check_eq("sh_b_hs", 512'(r_b), 512'(1));
    check_eq("sh_awaddr", 512'(awaddr_seen), 512'(0));
    check_eq("sh_latency", 512'(r_lat), 512'(7));
    check_eq("sh_err", 512'(err), 512'(0));
    check_eq("sh_rdata_kept", 512'(rdata_out), 512'(32'h00000080));

    // misaligned word load at 0x2
    xfer(1'b0, 2'b10, 1'b0, 29'h02, 32'd0, 0, 2'b00, '0, 1'b0);
    check_eq("mis_latency", 512'(r_lat), 512'(2));
    check_eq("mis_err", 512'(err), 512'(1));
    check_eq("mis_no_arvalid", 512'(r_arv), 512'(0));

    // reserved size store at aligned address
    xfer(1'b1, 2'b11, 1'b0, 29'h100, 32'h1, 0, 2'b00, '0, 1'b0);
    check_eq("rsvd_latency", 512'(r_lat), 512'(2));
    check_eq("rsvd_err", 512'(err), 512'(1));
    check_eq("rsvd_no_awvalid", 512'(r_awv + r_wv), 512'(0));

    // store byte at 0x21 with SLVERR
    xfer(1'b1, 2'b00, 1'b0, 29'h1061, 32'h777777A5, 0, 2'b10, '0, 1'b0);
    exp_wd = 512'hA5;
    exp_wd = exp_wd << 264;
    exp_st = 64'h1;
    exp_st = exp_st << 33;
    check_eq("sb_wdata", wdata_seen, exp_wd);
    check_eq("sb_wstrb", 512'(wstrb_seen), 512'(exp_st));
    check_eq("sb_awaddr", 512'(awaddr_seen), 512'(29'h1040));
    check_eq("sb_latency", 512'(r_lat), 512'(4));
    check_eq("sb_slverr", 512'(err), 512'(1));

    // load half signed at 0x4A, OKAY response clears err
    bus = 512'hFF8001;
    bus = bus << 80;
    xfer(1'b0, 2'b01, 1'b1, 29'h4A, 32'd0, 0, 2'b00, bus, 1'b0);
    check_eq("lh_sext", 512'(rdata_out), 512'(32'hFFFF8001));
    check_eq("lh_err", 512'(err), 512'(0));
    check_eq("lh_araddr", 512'(araddr_seen), 512'(29'h40));

    // load with DECERR
    bus = 512'h11223344;
    xfer(1'b0, 2'b10, 1'b0, 29'h200, 32'd0, 0, 2'b11, bus, 1'b0);
    check_eq("lw_decerr", 512'(err), 512'(1));
    check_eq("lw_decerr_data", 512'(rdata_out), 512'(32'h11223344));

    // enable pulsed while busy: no second transaction
    xfer(1'b0, 2'b10, 1'b0, 29'h300, 32'd0, 0, 2'b00, '0, 1'b1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (arvalid || awvalid || busy || done) stray++;
    end
    check_eq("busy_enable_single_ar", 512'(r_ar), 512'(1));
    check_eq("busy_enable_no_stray", 512'(stray), 512'(0));

    // reset in the cycle after arvalid rises
    is_store = 1'b0; size = 2'b10; addr = 29'h80; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check_eq("mid_arvalid_up", 512'(arvalid), 512'(1));
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valids", 512'({arvalid, rready, awvalid, wvalid, bready}), 512'(0));
    check_eq("mid_rst_status", 512'({busy, done, err}), 512'(0));
    rstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (arvalid || busy || done) stray++;
    end
    check_eq("mid_rst_idle", 512'(stray), 512'(0));

    // recovery after reset
    bus = 512'hCAFEF00D;
    xfer(1'b0, 2'b10, 1'b0, 29'h1C0, 32'd0, 0, 2'b00, bus, 1'b0);
    check_eq("recover_latency", 512'(r_lat), 512'(4));
    check_eq("recover_rdata", 512'(rdata_out), 512'(32'hCAFEF00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mem_unit.md
Name: axi_mem_unit

Overview:
- Parametrised load/store engine for the core's memory stage.
- Turns one 8/16/32-bit access request into a single-beat AXI4 read or write on a wide data bus.
- Read path: selects the byte lane and sign- or zero-extends the result. Write path: produces shifted write data and a byte-strobe mask.
- Sits between the exec stage and the DDR/cache AXI interconnect; returns a one-cycle done pulse plus result/error.

Parameters:
- ADDR_W, 29, AXI byte-address width.
- BUS_W, 512, AXI data width in bits; power of two, 32..1024.
- ID, 0, constant value driven on arid/awid (4 bits).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  start request; sampled only in IDLE
- is_store  in  1  1=store, 0=load
- size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- sign_ext  in  1  loads: 1=sign-extend, 0=zero-extend
- addr  in  ADDR_W  byte address
- wdata_in  in  32  store data, right-aligned
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, reserved size, or non-OKAY resp
- rdata_out  out  32  load result, held until next done
- busy  out  1  high from accept until done
- araddr/awaddr  out  ADDR_W  bus-aligned address
- arvalid/awvalid/wvalid/rready/bready  out  1  AXI handshakes
- arready/awready/wready/rvalid/bvalid/rlast  in  1
- rdata  in  BUS_W; wdata  out  BUS_W; wstrb  out  BUS_W/8; wlast  out  1
- rresp/bresp  in  2
- arid/awid  out  4; arlen/awlen  out  8; arsize/awsize  out  3; arburst/awburst  out  2

Behaviour:
- Reset: all valid/ready outputs 0, done=0, err=0, busy=0, rdata_out=0, wdata=0, wstrb=0, wlast=0, addresses 0, state IDLE.
- Reset mid-transaction abandons it immediately; the interconnect is reset alongside.
- Constant outputs (also during reset): arlen=awlen=0, arburst=awburst=01, arsize=awsize=log2(BUS_W/8), arid=awid=ID.
- Let OFF = addr[log2(BUS_W/8)-1:0].
  - Bus address = addr with OFF cleared.
  - Misaligned = (size==01 && addr[0]) or (size==10 && addr[1:0]!=0) or size==11.
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP, FIN.
- IDLE:
  - enable=1 latches all request inputs and sets busy.
  - Misaligned request → FIN with err=1; no AXI activity.
  - Otherwise load → RADDR (arvalid=1 next cycle); store → WADDR (awvalid=wvalid=wlast=1 next cycle).
- RADDR: hold arvalid until arready; clear it in the handshake cycle, then set rready=1 → RDATA.
- RDATA:
  - On rvalid&&rready: latch the lane at byte OFF, take bits [8/16/32 per size], extend per sign_ext into rdata_out.
  - err=(rresp!=0). Drop rready → FIN.
  - rlast is ignored (single beat).
- WADDR:
  - awvalid and wvalid are dropped independently on their own handshake.
  - wdata = wdata_in (low size bytes) shifted left by 8*OFF, other bits 0.
  - wstrb = (1/3/F) << OFF.
  - When both handshakes are complete (same or different cycles): wvalid=wlast=0, bready=1 → WRESP.
- WRESP: on bvalid: err=(bresp!=0), bready=0 → FIN.
- FIN: done=1 for exactly one cycle, busy=0 → IDLE.
  - err stays valid through the done cycle; rdata_out is unchanged for stores.
- enable while busy is ignored; no queuing.
- Latency from enable to done:
  - misaligned: 2 cycles
  - load with zero-wait slave: 4 cycles
  - store with zero-wait slave: 4 cycles

Decomposition:
- Package axi_mem_pkg:
  - state enum
  - size encodings
  - AXI constants: BURST_INCR, RESP_OKAY
  - function lane_mask(size)
- Sub-module mem_lane_align (combinational): OFF + size + sign_ext + wdata_in/rdata → write data, strobes, extracted load word.

Test Plan:
- Load word, addr=0x0000_0044, rdata word at byte 4 = 0xDEADBEEF, zero-wait slave → araddr=0x0000_0040, done on cycle 4, rdata_out=0xDEADBEEF, err=0.
- Load byte sign-extended, addr=0x3F, byte 63 of rdata = 0x80 → rdata_out=0xFFFFFF80. Same with sign_ext=0 → 0x00000080.
- Store half 0x1234 at addr=0x06, awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, wstrb=0x00..C0, wdata bits[63:48]=0x1234, single bready handshake, done=1.
- Misaligned word load at addr=0x2 → no arvalid ever, done at cycle 2 with err=1.
- Store with bresp=2'b10 (SLVERR) → done with err=1. Next load with rresp=00 → err=0.
- rstn asserted in the cycle after arvalid rises, and enable pulsed while busy → all valids 0 the next cycle, state IDLE; a busy-time enable produces no second transaction.
